pmu_bus_initiator: RTL and testbench
====================================

Name: pmu_bus_initiator

Overview:
Bus initiator for the PMU register interface (valid/ready, wstrb, wdata, addr, we). It takes single read or write commands from a local command port and issues them to the primary PMU window. If the primary does not answer within a bounded time, it retries the same access on the backup PMU window. It returns data and status to the requester, and is the host-side counterpart of the redundant PMU pair.

Parameters:
WORD_SIZE, 32, data width of bus and command/response words
WHISBONE_ADR, 32, bus address width
OFFSET_W, 12, width of register offset inside a PMU window (WHISBONE_ADR-20)
PRIMARY_BASE, 20'h3000_0, upper address bits of primary PMU window
BACKUP_BASE, 20'h3001_0, upper address bits of backup PMU window
TIMEOUT_CYCLES, 16, max cycles valid_o may stay high without ready_i (range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when both high on a clk edge
cmd_we_i  input  1  1=write, 0=read
cmd_offset_i  input  OFFSET_W  register offset within PMU window
cmd_wdata_i  input  WORD_SIZE  write data
cmd_wstrb_i  input  4  byte strobes for write
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed when both high
rsp_rdata_o  output  WORD_SIZE  read data (0 for writes and errors)
rsp_err_o  output  1  both windows timed out
rsp_backup_o  output  1  response came from backup window
valid_o  output  1  bus request
ready_i  input  1  bus completion from target(s)
wbs_we_o  output  1  bus write enable
wbs_adr_o  output  WHISBONE_ADR  bus address
wdata_o  output  WORD_SIZE  bus write data
wstrb_o  output  4  bus byte strobes (4'b0000 on reads)
rdata_i  input  WORD_SIZE  bus read data, valid with ready_i
primary_fail_cnt_o  output  8  saturating count of primary timeouts

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except cmd_ready_o=1. primary_fail_cnt_o=0.
- States: IDLE, REQ_PRI, GAP, REQ_BAK, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o:
  - latch we, offset, wdata, and wstrb (wstrb forced to 0 if read);
  - go to REQ_PRI;
  - valid_o rises the next cycle (1-cycle latency from accept).
- REQ_PRI:
  - valid_o=1; wbs_adr_o={PRIMARY_BASE,offset}; we/wdata/wstrb held stable until completion.
  - Timeout counter starts at 0 and increments each cycle with ready_i=0.
  - ready_i=1: capture rdata_i (reads only; writes capture 0), backup=0, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with ready_i=0: increment primary_fail_cnt_o (saturate at 255), go to GAP.
  - ready_i on the same cycle as the timeout: ready wins, no timeout.
- GAP: valid_o=0 for exactly one cycle, counter cleared, then REQ_BAK.
- REQ_BAK: same as REQ_PRI with wbs_adr_o={BACKUP_BASE,offset}.
  - ready_i: capture data, backup=1, err=0, go to RESP.
  - Timeout: rdata=0, backup=1, err=1, go to RESP.
- valid_o is always deasserted the cycle after ready_i is sampled. A bus transaction is exactly valid_o cycles ending in one ready_i cycle.
- RESP: rsp_valid_o=1, with rdata/err/backup stable. On rsp_ready_i, go to IDLE and drop rsp_valid_o next cycle. cmd_ready_o=0 outside IDLE, so only one command is outstanding.
- ready_i outside REQ_PRI/REQ_BAK is ignored.
- rst mid-transaction: immediate return to IDLE, valid_o=0, the pending command is discarded, fail count cleared.
- Throughput: best case accept -> rsp_valid_o is 3 cycles (accept, request with ready_i same cycle, RESP).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, REQ_PRI=1, GAP=2, REQ_BAK=3, RESP=4, 3 bits);
  - PMU window bases 20'h3000_0 and 20'h3001_0, also used by PMU instantiations.
- One natural sub-module: bus_timeout_counter (8-bit counter with clear, enable, and terminal flag at TIMEOUT_CYCLES-1). All other logic stays in the main FSM.

Test Plan:
- Read, primary answers after 2 cycles with rdata_i=32'hDEAD_BEEF -> wbs_adr_o=32'h3000_0004 for offset 4; rsp_rdata_o=32'hDEADBEEF, err=0, backup=0, fail_cnt=0.
- Write offset 8, wdata 32'h0000_00A5, wstrb 4'b0001, ready_i on the first valid cycle -> single valid_o pulse, wbs_we_o=1, wstrb_o=4'b0001; rsp_rdata_o=0, err=0.
- Primary silent, backup answers 32'h1234_5678 -> valid_o high 16 cycles at 32'h3000_0xxx, 1 low cycle, then at 32'h3001_0xxx; rsp backup=1, err=0, fail_cnt=1.
- Both silent -> 16+1+16 cycles, then rsp err=1, rdata=0, backup=1; fail_cnt saturates at 255 after 300 such commands.
- Hold rsp_ready_i=0 for 10 cycles with new cmd_valid_i asserted -> cmd_ready_o stays 0 and the response is held stable; command accepted only after rsp_ready_i.
- Assert rst during REQ_BAK -> valid_o=0 and cmd_ready_o=1 without a clock edge; no response emitted; fail_cnt=0.

Source files
------------

// File: rtl/pmu_bus_initiator_pkg.sv
// Shared definitions for the PMU bus initiator: FSM encoding and the PMU window bases
// that the redundant PMU instantiations decode as well.
package pmu_bus_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_PRI = 3'd1,
        ST_GAP     = 3'd2,
        ST_REQ_BAK = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [19:0] PMU_PRIMARY_BASE = 20'h3000_0;
    localparam logic [19:0] PMU_BACKUP_BASE  = 20'h3001_0;

    // Failure counters stick at all-ones instead of wrapping back to a healthy-looking zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pmu_bus_initiator_bus_timeout_counter.sv
// Counts bus request cycles that go unanswered; terminal marks the last cycle the
// initiator may keep valid_o high before abandoning the current window.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/pmu_bus_initiator.sv
// Host-side initiator for the redundant PMU pair: one command at a time, tried on the
// primary window first and retried on the backup window after a bus timeout.
module pmu_bus_initiator
    import pmu_bus_initiator_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int WHISBONE_ADR   = 32,
    parameter int OFFSET_W       = 12,
    parameter logic [WHISBONE_ADR-OFFSET_W-1:0] PRIMARY_BASE = PMU_PRIMARY_BASE,
    parameter logic [WHISBONE_ADR-OFFSET_W-1:0] BACKUP_BASE  = PMU_BACKUP_BASE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [OFFSET_W-1:0]     cmd_offset_i,
    input  logic [WORD_SIZE-1:0]    cmd_wdata_i,
    input  logic [3:0]              cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WORD_SIZE-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_backup_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    wbs_we_o,
    output logic [WHISBONE_ADR-1:0] wbs_adr_o,
    output logic [WORD_SIZE-1:0]    wdata_o,
    output logic [3:0]              wstrb_o,
    input  logic [WORD_SIZE-1:0]    rdata_i,
    output logic [7:0]              primary_fail_cnt_o
);

    // Handshakes (cmd, rsp and bus alike): a transfer happens on a rising clk edge where
    // valid and ready are both high; a raised valid and its payload hold until then.

    state_t state;
    state_t state_next;

    logic                 we_q;
    logic [OFFSET_W-1:0]  offset_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [3:0]           wstrb_q;

    logic [WORD_SIZE-1:0] rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 rsp_backup_q;
    logic [7:0]           fail_cnt_q;

    logic                 accept;
    logic                 in_req;
    logic                 tmo_terminal;
    logic                 rsp_load;
    logic [WORD_SIZE-1:0] rsp_rdata_d;
    logic                 rsp_err_d;
    logic                 rsp_backup_d;
    logic                 fail_inc;

    assign in_req = (state == ST_REQ_PRI) || (state == ST_REQ_BAK);
    assign accept = cmd_valid_i && cmd_ready_o;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_req),
        .enable  (in_req && !ready_i),
        .terminal(tmo_terminal)
    );

    always_comb begin
        state_next   = state;
        cmd_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        valid_o      = 1'b0;
        wbs_we_o     = 1'b0;
        wbs_adr_o    = '0;
        wdata_o      = '0;
        wstrb_o      = 4'b0000;
        rsp_load     = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        rsp_backup_d = 1'b0;
        fail_inc     = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_next = ST_REQ_PRI;
                end
            end
            ST_REQ_PRI: begin
                valid_o   = 1'b1;
                wbs_we_o  = we_q;
                wbs_adr_o = {PRIMARY_BASE, offset_q};
                wdata_o   = wdata_q;
                wstrb_o   = wstrb_q;
                // A completion on the terminal cycle still counts as an answer.
                if (ready_i) begin
                    rsp_load    = 1'b1;
                    rsp_rdata_d = we_q ? '0 : rdata_i;
                    state_next  = ST_RESP;
                end else if (tmo_terminal) begin
                    fail_inc   = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_REQ_BAK;
            end
            ST_REQ_BAK: begin
                valid_o      = 1'b1;
                wbs_we_o     = we_q;
                wbs_adr_o    = {BACKUP_BASE, offset_q};
                wdata_o      = wdata_q;
                wstrb_o      = wstrb_q;
                rsp_backup_d = 1'b1;
                if (ready_i) begin
                    rsp_load    = 1'b1;
                    rsp_rdata_d = we_q ? '0 : rdata_i;
                    state_next  = ST_RESP;
                end else if (tmo_terminal) begin
                    rsp_load   = 1'b1;
                    rsp_err_d  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            offset_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 4'b0000;
        end else if (accept) begin
            we_q     <= cmd_we_i;
            offset_q <= cmd_offset_i;
            wdata_q  <= cmd_wdata_i;
            wstrb_q  <= cmd_we_i ? cmd_wstrb_i : 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_backup_q <= 1'b0;
            fail_cnt_q   <= 8'd0;
        end else begin
            if (rsp_load) begin
                rsp_rdata_q  <= rsp_rdata_d;
                rsp_err_q    <= rsp_err_d;
                rsp_backup_q <= rsp_backup_d;
            end
            if (fail_inc) begin
                fail_cnt_q <= sat_inc8(fail_cnt_q);
            end
        end
    end

    assign rsp_rdata_o        = rsp_rdata_q;
    assign rsp_err_o          = rsp_err_q;
    assign rsp_backup_o       = rsp_backup_q;
    assign primary_fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_pmu_bus_initiator.sv
// Directed and randomized transactions against a window-level model of the PMU
// initiator: how long each window is driven, what answers, and what comes back.
module tb_pmu_bus_initiator;

    localparam int T = 16;
    localparam int BUS_BOUND = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [11:0] cmd_offset_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_backup_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        wbs_we_o;
    logic [31:0] wbs_adr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic [31:0] rdata_i = '0;
    logic [7:0]  primary_fail_cnt_o;

    int checks = 0;
    int errors = 0;

    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_fail = 0;

    pmu_bus_initiator dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_we_i          (cmd_we_i),
        .cmd_offset_i      (cmd_offset_i),
        .cmd_wdata_i       (cmd_wdata_i),
        .cmd_wstrb_i       (cmd_wstrb_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_rdata_o       (rsp_rdata_o),
        .rsp_err_o         (rsp_err_o),
        .rsp_backup_o      (rsp_backup_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .wbs_we_o          (wbs_we_o),
        .wbs_adr_o         (wbs_adr_o),
        .wdata_o           (wdata_o),
        .wstrb_o           (wstrb_o),
        .rdata_i           (rdata_i),
        .primary_fail_cnt_o(primary_fail_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Window model: a target answering after lat unanswered cycles completes within the
    // window only if lat < T; otherwise valid_o is held exactly T cycles.
    function automatic bit answers(input int lat);
        return (lat >= 0) && (lat < T);
    endfunction

    function automatic int window_cycles(input int lat);
        return answers(lat) ? lat + 1 : T;
    endfunction

    // Plays the target side of one window, starting at a negedge where valid_o should be high.
    task automatic bus_phase(input int lat, input logic [31:0] exp_adr, input logic [31:0] data,
                             output int cycles, output logic answered);
        cycles = 0;
        answered = 1'b0;
        while (valid_o === 1'b1 && cycles < BUS_BOUND && !answered) begin
            chk("bus_adr", wbs_adr_o, exp_adr);
            chk("bus_we", {31'd0, wbs_we_o}, {31'd0, exp_we});
            chk("bus_wdata", wdata_o, exp_wdata);
            chk("bus_wstrb", {28'd0, wstrb_o}, {28'd0, exp_wstrb});
            if (cycles == lat) begin
                ready_i = 1'b1;
                rdata_i = data;
                answered = 1'b1;
            end
            cycles++;
            @(negedge clk);
            ready_i = 1'b0;
            rdata_i = $urandom;
        end
    endtask

    task automatic do_txn(input logic we, input logic [11:0] off, input logic [31:0] wd,
                          input logic [3:0] ws, input int pri_lat, input logic [31:0] pri_data,
                          input int bak_lat, input logic [31:0] bak_data, input int rsp_hold);
        int          pc;
        int          bc;
        logic        pa;
        logic        ba;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_backup;

        exp_we    = we;
        exp_wdata = wd;
        exp_wstrb = we ? ws : 4'b0000;

        chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i  = 1'b1;
        cmd_we_i     = we;
        cmd_offset_i = off;
        cmd_wdata_i  = wd;
        cmd_wstrb_i  = ws;
        @(negedge clk);
        cmd_valid_i  = 1'b0;
        cmd_we_i     = $urandom_range(0, 1);
        cmd_offset_i = 12'($urandom);
        cmd_wdata_i  = $urandom;
        cmd_wstrb_i  = 4'($urandom);
        chk("cmd_ready_busy", {31'd0, cmd_ready_o}, 32'd0);
        chk("valid_after_accept", {31'd0, valid_o}, 32'd1);

        bus_phase(pri_lat, {20'h3000_0, off}, pri_data, pc, pa);
        chk("pri_cycles", pc, window_cycles(pri_lat));
        chk("pri_answered", {31'd0, pa}, {31'd0, answers(pri_lat)});

        if (answers(pri_lat)) begin
            exp_rdata  = we ? 32'd0 : pri_data;
            exp_err    = 1'b0;
            exp_backup = 1'b0;
        end else begin
            if (exp_fail < 255) exp_fail++;
            chk("gap_valid_low", {31'd0, valid_o}, 32'd0);
            ready_i = 1'b1;
            @(negedge clk);
            ready_i = 1'b0;
            bus_phase(bak_lat, {20'h3001_0, off}, bak_data, bc, ba);
            chk("bak_cycles", bc, window_cycles(bak_lat));
            exp_rdata  = (answers(bak_lat) && !we) ? bak_data : 32'd0;
            exp_err    = !answers(bak_lat);
            exp_backup = 1'b1;
        end

        chk("valid_dropped", {31'd0, valid_o}, 32'd0);
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
        chk("rsp_backup", {31'd0, rsp_backup_o}, {31'd0, exp_backup});
        chk("fail_cnt", {24'd0, primary_fail_cnt_o}, exp_fail);

        for (int i = 0; i < rsp_hold; i++) begin
            cmd_valid_i = 1'b1;
            @(negedge clk);
            chk("hold_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
            chk("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata_o, exp_rdata);
            chk("hold_valid_low", {31'd0, valid_o}, 32'd0);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
        chk("back_to_idle", {31'd0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_adr", wbs_adr_o, 32'd0);
        chk("rst_wstrb", {28'd0, wstrb_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_fail", {24'd0, primary_fail_cnt_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read answered by primary, write answered on first valid cycle
        do_txn(1'b0, 12'h004, 32'h1111_2222, 4'hF, 2, 32'hDEAD_BEEF, -1, 32'd0, 0);
        do_txn(1'b1, 12'h008, 32'h0000_00A5, 4'b0001, 0, 32'hFFFF_FFFF, -1, 32'd0, 0);
        // Primary silent, backup answers; both silent
        do_txn(1'b0, 12'h010, 32'h0, 4'h0, -1, 32'd0, 3, 32'h1234_5678, 0);
        do_txn(1'b0, 12'h020, 32'h0, 4'h0, -1, 32'd0, -1, 32'd0, 0);
        // Response back-pressure with a competing command waiting
        do_txn(1'b1, 12'hABC, 32'hCAFE_F00D, 4'b1010, 1, 32'h5555_5555, -1, 32'd0, 10);
        // Answers on the very last cycle of each window win over the timeout
        do_txn(1'b0, 12'hFFF, 32'h0, 4'h0, T - 1, 32'h0BAD_F00D, -1, 32'd0, 0);
        do_txn(1'b0, 12'h000, 32'h0, 4'h0, -1, 32'd0, T - 1, 32'h7777_8888, 0);
        do_txn(1'b1, 12'h123, 32'h0102_0304, 4'b1100, -1, 32'd0, T - 1, 32'hFFFF_0000, 0);

        // Randomized traffic: latencies at or beyond T model a silent target
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, T + 4)), $urandom,
                   int'($urandom_range(0, T + 4)), $urandom, int'($urandom_range(0, 3)));
        end

        // Drive the failure counter into saturation
        for (int n = 0; n < 300; n++) begin
            do_txn(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom),
                   -1, 32'd0, -1, 32'd0, 0);
        end
        chk("fail_saturated", {24'd0, primary_fail_cnt_o}, 32'd255);

        // Asynchronous reset in the middle of the backup request
        cmd_valid_i  = 1'b1;
        cmd_we_i     = 1'b0;
        cmd_offset_i = 12'h044;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (T + 4) @(negedge clk);
        chk("mid_bak_valid", {31'd0, valid_o}, 32'd1);
        chk("mid_bak_adr", wbs_adr_o, 32'h3001_0044);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("async_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("async_rst_fail", {24'd0, primary_fail_cnt_o}, 32'd0);
        exp_fail = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
            chk("post_rst_no_valid", {31'd0, valid_o}, 32'd0);
        end
        do_txn(1'b0, 12'h0F0, 32'h0, 4'h0, -1, 32'd0, 5, 32'h600D_D00D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
